// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store; MEM wins unless IF has waited MAX_STREAK grants.
// Latency: grant on the edge after the request, valid/err pulse on the cycle after bus_ready or timeout.
// Backpressure: requesters hold rq until their pulse; stall_if/stall_mem are combinational.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int MAX_STREAK = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_rq,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_valid,
    output logic [31:0]       if_rdata,
    input  logic              mem_rq,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wstrb,
    output logic              mem_valid,
    output logic [31:0]       mem_rdata,
    output logic              mem_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_wstrb,
    input  logic              bus_ready,
    input  logic [31:0]       bus_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    typedef enum logic [1:0] {IDLE, GNT_IF, GNT_MEM, DROP_IF} state_t;

    state_t     state;
    logic [2:0] streak;
    logic [7:0] tmo_cnt;
    logic       streak_full;
    logic       tmo_last;

    assign streak_full = (streak == 3'(MAX_STREAK));
    assign tmo_last    = (tmo_cnt == 8'(TIMEOUT - 1));
    assign bus_req     = (state != IDLE);
    assign stall_if    = if_rq && !if_valid;
    assign stall_mem   = mem_rq && !mem_valid && !mem_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            streak    <= '0;
            tmo_cnt   <= '0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wstrb <= '0;
            if_valid  <= 1'b0;
            if_rdata  <= '0;
            mem_valid <= 1'b0;
            mem_rdata <= '0;
            mem_err   <= 1'b0;
        end else begin
            if_valid  <= 1'b0;
            mem_valid <= 1'b0;
            mem_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (!if_rq)
                        streak <= '0;
                    // MEM yields only once IF has been passed over MAX_STREAK times in a row
                    if (mem_rq && !(if_rq && streak_full)) begin
                        state     <= GNT_MEM;
                        tmo_cnt   <= '0;
                        bus_we    <= mem_we;
                        bus_addr  <= mem_addr;
                        bus_wdata <= mem_wdata;
                        bus_wstrb <= mem_wstrb;
                        if (if_rq)
                            streak <= streak + 3'd1;
                    end else if (if_rq && !if_flush) begin
                        state     <= GNT_IF;
                        tmo_cnt   <= '0;
                        streak    <= '0;
                        bus_we    <= 1'b0;
                        bus_addr  <= if_addr;
                        bus_wdata <= '0;
                        bus_wstrb <= '0;
                    end
                end
                GNT_MEM: begin
                    if (bus_ready) begin
                        state     <= IDLE;
                        mem_valid <= 1'b1;
                        mem_rdata <= bus_we ? 32'd0 : bus_rdata;
                    end else if (tmo_last) begin
                        state   <= IDLE;
                        mem_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                GNT_IF: begin
                    if (bus_ready) begin
                        state <= IDLE;
                        if (!if_flush) begin
                            if_valid <= 1'b1;
                            if_rdata <= bus_rdata;
                        end
                    end else if (tmo_last) begin
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                        if (if_flush)
                            state <= DROP_IF;
                    end
                end
                DROP_IF: begin
                    // the bus access is already in flight; wait it out silently
                    if (bus_ready || tmo_last)
                        state <= IDLE;
                    else
                        tmo_cnt <= tmo_cnt + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_rq = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_flush = 1'b0;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        mem_rq = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        stall_if;
    logic        stall_mem;

    mem_port_arbiter #(.ADDR_W(32), .MAX_STREAK(4), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .if_rq(if_rq), .if_addr(if_addr), .if_flush(if_flush),
        .if_valid(if_valid), .if_rdata(if_rdata),
        .mem_rq(mem_rq), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 if_valid, 1 mem_valid, 2 mem_err
        int          cyc;
        logic [31:0] data;
    } ev_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          start;
        int          len;
    } gnt_t;

    ev_t  ev_q[$];
    gnt_t gq[$];
    int   compared = 0;
    int   failed = 0;
    int   cyc = 0;
    int   ready_delay = 0;
    bit   ready_never = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int c, input logic [31:0] data);
        ev_t e;
        e.kind = kind; e.cyc = c; e.data = data;
        ev_q.push_back(e);
    endtask

    task automatic push_gnt(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input int start, input int len);
        gnt_t g;
        g.we = we; g.addr = addr; g.wdata = wdata; g.wstrb = wstrb; g.start = start; g.len = len;
        gq.push_back(g);
    endtask

    // Memory model: completes after ready_delay cycles of bus_req, data derived from the address
    int rsp_cnt = 0;
    bit rsp_prev = 1'b0;
    always @(posedge clk) begin
        #2;
        if (bus_req === 1'b1)
            rsp_cnt = rsp_prev ? rsp_cnt + 1 : 0;
        rsp_prev  = (bus_req === 1'b1);
        bus_ready = (bus_req === 1'b1) && !ready_never && (rsp_cnt == ready_delay);
        bus_rdata = {bus_addr[15:0], 16'hC0DE};
    end

    // Monitor: pops expected pulses and grants as the DUT presents them
    logic prev_req = 1'b0;
    bit   have_g = 1'b0;
    gnt_t cur_g;
    always @(negedge clk) begin
        ev_t         e;
        int          nv;
        int          kind;
        logic [31:0] data;
        nv = int'(if_valid === 1'b1) + int'(mem_valid === 1'b1) + int'(mem_err === 1'b1);
        if (nv > 1)
            check("pulse_exclusive", 32'(nv), 32'd1);
        if (nv > 0) begin
            kind = (mem_err === 1'b1) ? 2 : (mem_valid === 1'b1) ? 1 : 0;
            data = (kind == 0) ? if_rdata : mem_rdata;
            if (ev_q.size() == 0) begin
                check("unexpected_pulse_kind", 32'(kind), 32'hFFFF_FFFF);
            end else begin
                e = ev_q.pop_front();
                check("pulse_kind", 32'(kind), 32'(e.kind));
                check("pulse_cycle", 32'(cyc), 32'(e.cyc));
                if (kind != 2)
                    check("pulse_rdata", data, e.data);
            end
        end
        if (bus_req === 1'b1 && !prev_req) begin
            if (gq.size() == 0) begin
                check("unexpected_grant_addr", bus_addr, 32'hFFFF_FFFF);
            end else begin
                cur_g  = gq.pop_front();
                have_g = 1'b1;
                check("grant_cycle", 32'(cyc), 32'(cur_g.start));
                check("grant_we", 32'(bus_we), 32'(cur_g.we));
                check("grant_addr", bus_addr, cur_g.addr);
                check("grant_wdata", bus_wdata, cur_g.wdata);
                check("grant_wstrb", 32'(bus_wstrb), 32'(cur_g.wstrb));
            end
        end
        if (bus_req !== 1'b1 && prev_req && have_g) begin
            check("grant_len", 32'(cyc - cur_g.start), 32'(cur_g.len));
            have_g = 1'b0;
        end
        prev_req = (bus_req === 1'b1);
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mem_wait_done();
        int i = 0;
        do begin
            step(1);
            i++;
        end while (!(mem_valid || mem_err) && i < 40);
        check("mem_done_in_time", 32'(mem_valid || mem_err), 32'd1);
        check("stall_mem_at_done", 32'(stall_mem), 32'd0);
    endtask

    task automatic if_wait_done();
        int i = 0;
        do begin
            step(1);
            i++;
        end while (!if_valid && i < 40);
        check("if_done_in_time", 32'(if_valid), 32'd1);
        check("stall_if_at_done", 32'(stall_if), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int t0;

        // reset state
        step(2);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_pulses", 32'({if_valid, mem_valid, mem_err}), 32'd0);
        check("rst_rdata", if_rdata | mem_rdata, 32'd0);
        reset = 1'b0;
        step(2);

        // simultaneous requests, ready in the grant cycle: MEM first, then IF
        t0 = cyc;
        ready_delay = 0;
        push_gnt(1'b0, 32'h1000, 32'h1111_2222, 4'hF, t0 + 1, 1);
        push_ev(1, t0 + 2, 32'h1000_C0DE);
        push_gnt(1'b0, 32'h2000, 32'h0, 4'h0, t0 + 3, 1);
        push_ev(0, t0 + 4, 32'h2000_C0DE);
        mem_we = 1'b0; mem_addr = 32'h1000; mem_wdata = 32'h1111_2222; mem_wstrb = 4'hF; mem_rq = 1'b1;
        if_addr = 32'h2000; if_rq = 1'b1;
        #1;
        check("stall_if_waiting", 32'(stall_if), 32'd1);
        check("stall_mem_waiting", 32'(stall_mem), 32'd1);
        fork
            begin mem_wait_done(); mem_rq = 1'b0; end
            begin if_wait_done(); if_rq = 1'b0; end
        join
        step(3);

        // MEM streak with IF waiting: M,M,M,M,I,M,M
        t0 = cyc;
        push_gnt(1'b0, 32'h4000, 32'h0, 4'h0, t0 + 1, 1);  push_ev(1, t0 + 2, 32'h4000_C0DE);
        push_gnt(1'b0, 32'h4004, 32'h0, 4'h0, t0 + 3, 1);  push_ev(1, t0 + 4, 32'h4004_C0DE);
        push_gnt(1'b0, 32'h4008, 32'h0, 4'h0, t0 + 5, 1);  push_ev(1, t0 + 6, 32'h4008_C0DE);
        push_gnt(1'b0, 32'h400C, 32'h0, 4'h0, t0 + 7, 1);  push_ev(1, t0 + 8, 32'h400C_C0DE);
        push_gnt(1'b0, 32'h3000, 32'h0, 4'h0, t0 + 9, 1);  push_ev(0, t0 + 10, 32'h3000_C0DE);
        push_gnt(1'b0, 32'h4010, 32'h0, 4'h0, t0 + 11, 1); push_ev(1, t0 + 12, 32'h4010_C0DE);
        push_gnt(1'b0, 32'h4014, 32'h0, 4'h0, t0 + 13, 1); push_ev(1, t0 + 14, 32'h4014_C0DE);
        mem_addr = 32'h4000; mem_wdata = '0; mem_wstrb = '0; mem_rq = 1'b1;
        if_addr = 32'h3000; if_rq = 1'b1;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    mem_wait_done();
                    mem_addr = mem_addr + 32'h4;
                end
                mem_rq = 1'b0;
            end
            begin if_wait_done(); if_rq = 1'b0; end
        join
        step(3);

        // flush while IF is on the bus: DROP_IF until ready, no if_valid
        t0 = cyc;
        ready_delay = 3;
        push_gnt(1'b0, 32'h5000, 32'h0, 4'h0, t0 + 1, 4);
        if_addr = 32'h5000; if_rq = 1'b1;
        step(2);
        if_flush = 1'b1;
        step(1);
        if_flush = 1'b0; if_rq = 1'b0;
        step(4);

        // flush coinciding with bus_ready: no if_valid
        t0 = cyc;
        ready_delay = 1;
        push_gnt(1'b0, 32'h5100, 32'h0, 4'h0, t0 + 1, 2);
        if_addr = 32'h5100; if_rq = 1'b1;
        step(2);
        if_flush = 1'b1;
        step(1);
        if_flush = 1'b0; if_rq = 1'b0;
        step(3);

        // store: latched we/addr/wdata/wstrb, mem_rdata forced to 0
        t0 = cyc;
        ready_delay = 1;
        push_gnt(1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011, t0 + 1, 2);
        push_ev(1, t0 + 3, 32'h0);
        mem_we = 1'b1; mem_addr = 32'h100; mem_wdata = 32'hDEAD_BEEF; mem_wstrb = 4'b0011; mem_rq = 1'b1;
        mem_wait_done();
        mem_rq = 1'b0; mem_we = 1'b0;
        step(3);

        // MEM timeout: 8 bus cycles then mem_err with bus_req already low
        t0 = cyc;
        ready_never = 1'b1;
        push_gnt(1'b0, 32'h6000, 32'h0, 4'h0, t0 + 1, 8);
        push_ev(2, t0 + 9, 32'h0);
        mem_addr = 32'h6000; mem_wdata = '0; mem_wstrb = '0; mem_rq = 1'b1;
        mem_wait_done();
        check("bus_req_after_err", 32'(bus_req), 32'd0);
        mem_rq = 1'b0;
        ready_never = 1'b0;
        step(3);

        // IF timeout: silent abort, then IF re-arbitrates and completes
        t0 = cyc;
        ready_never = 1'b1;
        ready_delay = 0;
        push_gnt(1'b0, 32'h7000, 32'h0, 4'h0, t0 + 1, 8);
        push_gnt(1'b0, 32'h7000, 32'h0, 4'h0, t0 + 10, 1);
        push_ev(0, t0 + 11, 32'h7000_C0DE);
        if_addr = 32'h7000; if_rq = 1'b1;
        step(9);
        ready_never = 1'b0;
        if_wait_done();
        if_rq = 1'b0;
        step(3);

        // reset in the middle of a MEM grant
        t0 = cyc;
        ready_never = 1'b1;
        push_gnt(1'b0, 32'h8000, 32'h0, 4'h0, t0 + 1, 3);
        mem_addr = 32'h8000; mem_rq = 1'b1;
        step(3);
        reset = 1'b1; mem_rq = 1'b0;
        step(1);
        check("midrst_bus_req", 32'(bus_req), 32'd0);
        check("midrst_bus_addr", bus_addr, 32'd0);
        check("midrst_pulses", 32'({if_valid, mem_valid, mem_err}), 32'd0);
        step(1);
        reset = 1'b0; ready_never = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(1);
            check("postrst_bus_req", 32'(bus_req), 32'd0);
            check("postrst_mem_valid", 32'(mem_valid), 32'd0);
        end

        step(3);
        check("ev_queue_drained", 32'(ev_q.size()), 32'd0);
        check("gnt_queue_drained", 32'(gq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
